// File: rtl/mdl_dac_serializer.sv
// rtl/mdl_dac_serializer.sv - float-format DAC serializer; IKA2151_DAC_PCM_OUT_EN adds linear PCM outputs
module mdl_dac_serializer (
    input  logic        i_EMUCLK,
    input  logic        i_MRST,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_SH1,
    input  logic        i_SH2,
    input  logic [15:0] i_L_SAMPLE,
    input  logic [15:0] i_R_SAMPLE,
    output logic        o_SO,
    output logic [15:0] o_EMU_L_SAMPLE,
    output logic [15:0] o_EMU_R_SAMPLE,
    output logic        o_EMU_SAMPLE_VALID
);

    logic        en;
    logic        sh1_z_q, sh2_z_q;
    logic        load_l, load_r, load;
    logic [15:0] conv_x;
    logic [2:0]  shift;
    logic [9:0]  mant;
    logic [15:0] word;
    logic [15:0] sr_q, sr_d;
    logic        so_q, so_d;
    logic [3:0]  cnt_q, cnt_d;

    assign en     = ~i_phi1_NCEN_n;
    assign load_l = en & i_SH1 & ~sh1_z_q;
    // Left wins a simultaneous strobe; the right word is dropped.
    assign load_r = en & i_SH2 & ~sh2_z_q & ~load_l;
    assign load   = load_l | load_r;
    assign conv_x = load_l ? i_L_SAMPLE : i_R_SAMPLE;

    // Shrink the shift while the next lower bit still matches the sign run.
    always_comb begin
        shift = 3'd6;
        for (int k = 5; k >= 0; k--) begin
            if ((conv_x[k + 9] == conv_x[15]) && (shift == 3'(k + 1))) begin
                shift = 3'(k);
            end
        end
        mant = 10'(conv_x >> shift);
        word = {shift + 3'd1, mant, 3'b000};
    end

    always_comb begin
        sr_d  = sr_q;
        so_d  = so_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = word;
            so_d  = word[0];
            cnt_d = 4'd0;
        end else if (en) begin
            if (cnt_q == 4'd15) begin
                sr_d = 16'h0000;
                so_d = 1'b0;
            end else begin
                sr_d  = {1'b0, sr_q[15:1]};
                so_d  = sr_q[1];
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            sr_q    <= 16'h0000;
            so_q    <= 1'b0;
            cnt_q   <= 4'd0;
            sh1_z_q <= 1'b1;
            sh2_z_q <= 1'b1;
        end else begin
            sr_q  <= sr_d;
            so_q  <= so_d;
            cnt_q <= cnt_d;
            if (en) begin
                sh1_z_q <= i_SH1;
                sh2_z_q <= i_SH2;
            end
        end
    end

    assign o_SO = so_q;

`ifdef IKA2151_DAC_PCM_OUT_EN
    logic [15:0] emu_l_q, emu_r_q;
    logic        valid_q, pend_q;
    logic [15:0] recon;

    // Low bits below the shift read zero, matching DAC quantization.
    assign recon = {{6{mant[9]}}, mant} << shift;

    always_ff @(posedge i_EMUCLK) begin
        if (i_MRST) begin
            emu_l_q <= 16'h0000;
            emu_r_q <= 16'h0000;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else if (en) begin
            valid_q <= pend_q;
            pend_q  <= load_r;
            if (load_l) begin
                emu_l_q <= recon;
            end
            if (load_r) begin
                emu_r_q <= recon;
            end
        end
    end

    assign o_EMU_L_SAMPLE     = emu_l_q;
    assign o_EMU_R_SAMPLE     = emu_r_q;
    assign o_EMU_SAMPLE_VALID = valid_q;
`else
    assign o_EMU_L_SAMPLE     = 16'h0000;
    assign o_EMU_R_SAMPLE     = 16'h0000;
    assign o_EMU_SAMPLE_VALID = 1'b0;
`endif

endmodule

// File: tb/tb_mdl_dac_serializer.sv
// tb/tb_mdl_dac_serializer.sv - self-checking bench for mdl_dac_serializer
module tb_mdl_dac_serializer;

    logic        clk = 1'b0;
    logic        mrst = 1'b1;
    logic        ncen = 1'b0;
    logic        sh1 = 1'b0;
    logic        sh2 = 1'b0;
    logic [15:0] l_smp = 16'h0000;
    logic [15:0] r_smp = 16'h0000;
    logic        so;
    logic [15:0] emu_l, emu_r;
    logic        emu_v;

    int checks = 0;
    int errors = 0;
    logic so_seen;

    mdl_dac_serializer dut (
        .i_EMUCLK          (clk),
        .i_MRST            (mrst),
        .i_phi1_NCEN_n     (ncen),
        .i_SH1             (sh1),
        .i_SH2             (sh2),
        .i_L_SAMPLE        (l_smp),
        .i_R_SAMPLE        (r_smp),
        .o_SO              (so),
        .o_EMU_L_SAMPLE    (emu_l),
        .o_EMU_R_SAMPLE    (emu_r),
        .o_EMU_SAMPLE_VALID(emu_v)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_shift(input logic [15:0] x);
        int v, s;
        v = int'($signed(x));
        s = 6;
        for (int t = 6; t >= 0; t--) begin
            if (((v >>> (t + 9)) == 0) || ((v >>> (t + 9)) == -1)) s = t;
        end
        return s;
    endfunction

    function automatic logic [15:0] m_word(input logic [15:0] x);
        int s, m;
        s = m_shift(x);
        m = (int'(x) >> s) & 32'h3FF;
        return 16'(((s + 1) << 13) | (m << 3));
    endfunction

    function automatic logic [15:0] m_recon(input logic [15:0] x);
        int s, m;
        s = m_shift(x);
        m = (int'(x) >> s) & 32'h3FF;
        if (m >= 512) m = m - 1024;
        return 16'(m * (1 << s));
    endfunction

    // Reference: current word plus index of the bit that should be on the line.
    logic        m_ready = 1'b0;
    logic        m_sh1z, m_sh2z;
    logic [15:0] m_wd;
    int          m_k;
    logic [15:0] m_el, m_er;
    logic        m_valid, m_pend;

    always @(posedge clk) begin
        if (mrst) begin
            m_ready = 1'b1;
            m_sh1z = 1'b1; m_sh2z = 1'b1;
            m_wd = 16'h0; m_k = 16;
            m_el = 16'h0; m_er = 16'h0;
            m_valid = 1'b0; m_pend = 1'b0;
        end else if (!ncen) begin
            m_valid = m_pend;
            m_pend = 1'b0;
            if (sh1 && !m_sh1z) begin
                m_wd = m_word(l_smp); m_k = 0; m_el = m_recon(l_smp);
            end else if (sh2 && !m_sh2z) begin
                m_wd = m_word(r_smp); m_k = 0; m_er = m_recon(r_smp); m_pend = 1'b1;
            end else if (m_k < 16) begin
                m_k++;
            end
            m_sh1z = sh1; m_sh2z = sh2;
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("so_model", 32'(so), (m_k < 16) ? 32'((m_wd >> m_k) & 16'h1) : 32'h0);
`ifdef IKA2151_DAC_PCM_OUT_EN
            chk("emu_l_model", 32'(emu_l), 32'(m_el));
            chk("emu_r_model", 32'(emu_r), 32'(m_er));
            chk("emu_v_model", 32'(emu_v), 32'(m_valid));
`else
            chk("emu_l_zero", 32'(emu_l), 32'h0);
            chk("emu_r_zero", 32'(emu_r), 32'h0);
            chk("emu_v_zero", 32'(emu_v), 32'h0);
`endif
        end
    end

    task automatic tick(input logic r, input logic n, input logic s1, input logic s2);
        @(negedge clk);
        so_seen = so;
        mrst = r; ncen = n; sh1 = s1; sh2 = s2;
    endtask

    task automatic do_word(input bit right, input logic [15:0] val,
                           output logic [15:0] w, output int vcnt, output logic tail);
        if (right) r_smp = val; else l_smp = val;
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, !right, right);
        vcnt = 0;
        for (int i = 0; i < 16; i++) begin
            tick(0, 0, !right && i < 2, right && i < 2);
            w[i] = so_seen;
            if (emu_v) vcnt++;
        end
        tick(0, 0, 0, 0);
        tail = so_seen;
        if (emu_v) vcnt++;
    endtask

    logic [15:0] w;
    logic [31:0] fw;
    logic        tail;
    int          vc, n, fpos, rst_cnt;
    bit          prev_en;
    logic [15:0] specials [8] = '{16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF,
                                  16'h01FF, 16'h0200, 16'hFE00, 16'hFDFF};

    initial begin
        chk("pin_7fff", 32'(m_word(16'h7FFF)), 32'hEFF8);
        chk("pin_8000", 32'(m_word(16'h8000)), 32'hF000);
        chk("pin_0123", 32'(m_word(16'h0123)), 32'h2918);
        chk("pin_ffff", 32'(m_word(16'hFFFF)), 32'h3FF8);
        chk("pin_rec7fff", 32'(m_recon(16'h7FFF)), 32'h7FC0);
        chk("pin_rec8000", 32'(m_recon(16'h8000)), 32'h8000);

        for (int i = 0; i < 6; i++) tick(1, i[0], i[1], i[0]);
        tick(1, 0, 1, 0);
        chk("rst_so", 32'(so_seen), 32'h0);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);
        chk("no_load_sh1_high", 32'(so_seen), 32'h0);

        do_word(0, 16'h7FFF, w, vc, tail);
        chk("word_7fff", 32'(w), 32'hEFF8);
        chk("tail_7fff", 32'(tail), 32'h0);
`ifdef IKA2151_DAC_PCM_OUT_EN
        chk("emu_l_7fff", 32'(emu_l), 32'h7FC0);
`endif
        do_word(0, 16'h8000, w, vc, tail);
        chk("word_8000", 32'(w), 32'hF000);
`ifdef IKA2151_DAC_PCM_OUT_EN
        chk("emu_l_8000", 32'(emu_l), 32'h8000);
`endif
        do_word(1, 16'h0123, w, vc, tail);
        chk("word_r_0123", 32'(w), 32'h2918);
        do_word(1, 16'hFFFF, w, vc, tail);
        chk("word_r_ffff", 32'(w), 32'h3FF8);
`ifdef IKA2151_DAC_PCM_OUT_EN
        chk("emu_r_ffff", 32'(emu_r), 32'hFFFF);
        chk("valid_pulses", 32'(vc), 32'd1);
`else
        chk("valid_pulses", 32'(vc), 32'd0);
`endif

        l_smp = 16'h0123; r_smp = 16'h7FFF;
        tick(0, 0, 0, 0);
        for (int i = 0; i < 33; i++) begin
            tick(0, 0, i < 4, i >= 16 && i < 20);
            if (i > 0) fw[i - 1] = so_seen;
        end
        chk("full_frame", fw, 32'hEFF8_2918);

        // Stall for 5 EMUCLKs while bit 4 (a one) is on the line.
        l_smp = 16'h0123;
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        n = 0; prev_en = 1'b1;
        for (int j = 0; j < 30 && n < 16; j++) begin
            tick(0, (j >= 4 && j < 9), j < 2, 0);
            if (prev_en) begin
                w[n] = so_seen; n++;
            end else begin
                chk("stall_hold", 32'(so_seen), 32'((16'h2918 >> (n - 1)) & 16'h1));
            end
            prev_en = !(j >= 4 && j < 9);
        end
        chk("stall_word", 32'(w), 32'h2918);

        l_smp = 16'h7FFF;
        tick(0, 0, 0, 0);
        tick(0, 0, 1, 0);
        for (int j = 0; j < 8; j++) tick(j == 7, 0, 1, 0);
        chk("bit7_before_rst", 32'(so_seen), 32'h1);
        tick(0, 0, 1, 0);
        chk("rst_mid_so", 32'(so_seen), 32'h0);
        tick(0, 0, 1, 0);
        chk("rst_no_reload", 32'(so_seen), 32'h0);
        do_word(0, 16'h0123, w, vc, tail);
        chk("restart_word", 32'(w), 32'h2918);

        fpos = 0; rst_cnt = 0;
        for (int i = 0; i < 6000; i++) begin
            logic r, nn, s1, s2;
            l_smp = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : 16'($urandom);
            r_smp = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : 16'($urandom);
            if (rst_cnt == 0 && $urandom_range(0, 399) == 0) rst_cnt = $urandom_range(1, 4);
            r = (rst_cnt != 0);
            if (rst_cnt != 0) rst_cnt--;
            nn = ($urandom_range(0, 2) == 0);
            s1 = (fpos < 4);
            s2 = (fpos >= 16 && fpos < 20);
            if ($urandom_range(0, 49) == 0) begin
                s1 = 1'($urandom); s2 = 1'($urandom);
            end
            tick(r, nn, s1, s2);
            if (!nn) fpos = (fpos + 1) % 32;
        end

        tick(0, 0, 0, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
